// File: rtl/demux_sched_1_8.sv
// Round-robin burst scheduler steering a valid/ready stream to one of 8 channels.
// Define DEMUX_SCHED_PRIO_EN for fixed-priority grant (channel 0 highest).
module demux_sched_1_8 #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [7:0]        chan_en,
  input  logic [7:0]        out_ready,
  output logic [7:0]        out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [2:0]        sel,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(BURST_LEN);

  typedef enum logic [1:0] {IDLE, ARB, SEND} state_t;

  state_t           state;
  logic [CNT_W-1:0] beat_cnt;
  logic             held;
  logic             drain;
  logic             accept;
  logic             burst_end;
  logic [2:0]       grant;

  assign held      = |out_valid;
  assign drain     = out_valid[sel] && out_ready[sel];
  assign burst_end = (beat_cnt == BURST_MAX) || !chan_en[sel];
  assign in_ready  = (state == SEND) && chan_en[sel] && (beat_cnt < BURST_MAX)
                     && (!held || out_ready[sel]);
  assign accept    = in_valid && in_ready;

  // Grant search; iterating from the far end lets the nearest match win.
  always_comb begin
    grant = sel;
`ifdef DEMUX_SCHED_PRIO_EN
    for (int i = 7; i >= 0; i--) begin
      if (chan_en[3'(i)]) grant = 3'(i);
    end
`else
    for (int i = 8; i >= 1; i--) begin
      if (chan_en[3'(sel + 3'(i))]) grant = 3'(sel + 3'(i));
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sel       <= 3'd7;
      beat_cnt  <= '0;
      out_valid <= 8'd0;
      out_data  <= '0;
      busy      <= 1'b0;
    end else begin
      // Datapath: load on accept, otherwise clear once the held beat drains.
      if (accept) begin
        out_data  <= in_data;
        out_valid <= 8'b1 << sel;
        beat_cnt  <= beat_cnt + CNT_W'(1);
      end else if (drain) begin
        out_valid <= 8'd0;
      end

      case (state)
        IDLE: begin
          if (in_valid && |chan_en) begin
            state <= ARB;
            busy  <= 1'b1;
          end
        end
        ARB: begin
          if (|chan_en) begin
            sel      <= grant;
            beat_cnt <= '0;
            state    <= SEND;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        SEND: begin
          if (burst_end && !held) begin
            if (in_valid) begin
              state <= ARB;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demux_sched_1_8.sv
// Scoreboard bench for demux_sched_1_8: directed bursts with hand-computed channel/data.
module tb_demux_sched_1_8;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [7:0] chan_en;
  logic [7:0] out_ready;
  logic [7:0] out_valid;
  logic [7:0] out_data;
  logic [2:0] sel;
  logic       busy;

`ifdef DEMUX_SCHED_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  int          checks = 0;
  int          failures = 0;
  logic [10:0] exp_q[$];
  logic [10:0] e;

  demux_sched_1_8 #(.DATA_W(8), .BURST_LEN(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .chan_en(chan_en), .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .sel(sel), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [2:0] ch, input logic [7:0] d);
    exp_q.push_back({ch, d});
  endtask

  // Monitor: every beat that drains is popped and compared against the scoreboard.
  always @(negedge clk) begin
    if (!rst && (out_valid & out_ready) != 8'd0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 32'(out_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("beat_valid", 32'(out_valid), 32'(8'b1 << e[10:8]));
        chk("beat_data", 32'(out_data), 32'(e[7:0]));
      end
    end
  end

  task automatic send(input int n, input logic [7:0] d0);
    int   sent = 0;
    int   cyc = 0;
    logic acc;
    in_valid = 1'b1;
    in_data  = d0;
    while (sent < n && cyc < 400) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        sent++;
        in_data = d0 + 8'(sent);
      end
      cyc++;
    end
    chk("send_done", 32'(sent), 32'(n));
  endtask

  task automatic wait_idle(input string name);
    int i;
    for (i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy && out_valid == 8'd0) break;
    end
    chk(name, 32'(i < 60), 32'd1);
  endtask

  task automatic sb_empty(input string name);
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic stall_check();
    int i;
    for (i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid != 8'd0) break;
    end
    chk("stall_seen", 32'(i < 40), 32'd1);
    for (int j = 0; j < 3; j++) begin
      if (j > 0) @(negedge clk);
      chk("stall_valid", 32'(out_valid), 32'h01);
      chk("stall_data", 32'(out_data), 32'hA5);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 8'hFF;
  endtask

  task automatic abort_ch3();
    int n = 0;
    int c = 0;
    while (n < 2 && c < 100) begin
      @(negedge clk);
      if (in_valid && in_ready) n++;
      c++;
    end
    chk("abort_two_accepts", 32'(n), 32'd2);
    @(posedge clk);
    #1;
    chan_en = 8'h40;
    @(negedge clk);
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    chk("abort_sel", 32'(sel), 32'd3);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'd0; chan_en = 8'hFF; out_ready = 8'hFF;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sel", 32'(sel), 32'd7);
    chk("rst_in_ready", 32'(in_ready), 32'd0);

    // All channels enabled: bursts of four rotate 0..7 and wrap to 0.
    for (int k = 0; k < 36; k++) push(PRIO ? 3'd0 : 3'((k / 4) % 8), 8'(8'h10 + k));
    send(36, 8'h10);
    in_valid = 1'b0;
    wait_idle("t1_idle");
    sb_empty("t1_sb_empty");
    chk("t1_sel", 32'(sel), 32'd0);

    // Two enabled channels alternate.
    chan_en = 8'b0010_0100;
    for (int k = 0; k < 16; k++) push(PRIO ? 3'd2 : ((k / 4) % 2 == 0 ? 3'd2 : 3'd5), 8'(8'h40 + k));
    send(16, 8'h40);
    in_valid = 1'b0;
    wait_idle("t2_idle");
    sb_empty("t2_sb_empty");
    chk("t2_sel", 32'(sel), PRIO ? 32'd2 : 32'd5);

    // Backpressure on channel 0 after the first beat.
    chan_en = 8'h01;
    out_ready = 8'hFE;
    for (int k = 0; k < 4; k++) push(3'd0, 8'(8'hA5 + k));
    fork
      send(4, 8'hA5);
      stall_check();
    join
    in_valid = 1'b0;
    wait_idle("t3_idle");
    sb_empty("t3_sb_empty");

    // Channel 3 disabled after two beats; remaining beats go to channel 6.
    chan_en = 8'h48;
    push(3'd3, 8'h60); push(3'd3, 8'h61);
    for (int k = 2; k < 6; k++) push(3'd6, 8'(8'h60 + k));
    fork
      send(6, 8'h60);
      abort_ch3();
    join
    in_valid = 1'b0;
    wait_idle("t4_idle");
    sb_empty("t4_sb_empty");
    chk("t4_sel", 32'(sel), 32'd6);

    // Reset mid-burst with a held beat: the held beat is discarded.
    chan_en = 8'hFF;
    push(PRIO ? 3'd0 : 3'd7, 8'h70);
    send(2, 8'h70);
    out_ready = 8'h00; in_valid = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t5_out_valid", 32'(out_valid), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_sel", 32'(sel), 32'd7);
    chk("t5_in_ready", 32'(in_ready), 32'd0);
    sb_empty("t5_sb_discard");
    out_ready = 8'hFF;
    for (int k = 0; k < 4; k++) push(3'd0, 8'(8'h80 + k));
    send(4, 8'h80);
    in_valid = 1'b0;
    wait_idle("t5_idle");
    sb_empty("t5_sb_empty");

    // No channel enabled: stays idle.
    chan_en = 8'h00;
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;

    // Re-enable all: round-robin continues at 1,2; fixed priority stays on 0.
    chan_en = 8'hFF;
    for (int k = 0; k < 8; k++) push(PRIO ? 3'd0 : (k < 4 ? 3'd1 : 3'd2), 8'(8'h90 + k));
    send(8, 8'h90);
    in_valid = 1'b0;
    wait_idle("t6_idle");
    sb_empty("t6_sb_empty");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
